// File: rtl/register_file_2r1w.sv
`default_nettype none
// ============================================================================
// Module      : register_file_2r1w
// Description : Two-read / one-write register file with registered read ports,
//               write-first bypass, optional hard-wired zero entry and a
//               post-reset clear sequencer that zeroes every entry.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   clock, all state updates on the rising edge
//   rst        in   synchronous active-high reset, restarts the clear sequence
//   rd_a_en    in   read port A request
//   rd_a_id    in   read port A index      [ADDR_WIDTH]
//   rd_a_data  out  read port A data, 1-cycle latency, held when not enabled
//   rd_b_en    in   read port B request
//   rd_b_id    in   read port B index      [ADDR_WIDTH]
//   rd_b_data  out  read port B data, 1-cycle latency, held when not enabled
//   wr_en      in   write request
//   wr_id      in   write index            [ADDR_WIDTH]
//   wr_data    in   write data             [DATA_WIDTH]
//   busy       out  high while the clear sequencer runs; requests ignored
// ============================================================================
module register_file_2r1w #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_a_en,
    input  logic [ADDR_WIDTH-1:0] rd_a_id,
    output logic [DATA_WIDTH-1:0] rd_a_data,
    input  logic                  rd_b_en,
    input  logic [ADDR_WIDTH-1:0] rd_b_id,
    output logic [DATA_WIDTH-1:0] rd_b_data,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_id,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy
);

    localparam int                    c_DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_LAST_IDX = {ADDR_WIDTH{1'b1}};
    localparam logic                  c_ZERO_EN  = (ZERO_REG != 0);

    localparam logic [0:0] c_ST_CLEAR = 1'b0;
    localparam logic [0:0] c_ST_IDLE  = 1'b1;

    logic [0:0]            r_state;
    logic [0:0]            w_state_next;
    logic [ADDR_WIDTH-1:0] r_clr_idx;
    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_a_data;
    logic [DATA_WIDTH-1:0] r_rd_b_data;

    logic                  w_idle;
    logic                  w_wr_ok;
    logic                  w_zero_a;
    logic                  w_zero_b;
    logic [DATA_WIDTH-1:0] w_rd_a_val;
    logic [DATA_WIDTH-1:0] w_rd_b_val;

    // ------------------------------------------------------------------
    // Sequencer: CLEAR walks every index once, then IDLE until next reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_CLEAR;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_CLEAR: begin
                if (r_clr_idx == c_LAST_IDX) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            c_ST_IDLE: begin
                w_state_next = c_ST_IDLE;
            end
            default: begin
                w_state_next = c_ST_CLEAR;
            end
        endcase
    end

    // Wraps back to 0 on the final clear edge, ready for the next reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr_idx <= '0;
        end else if (r_state == c_ST_CLEAR) begin
            r_clr_idx <= r_clr_idx + 1'b1;
        end
    end

    assign w_idle = (r_state == c_ST_IDLE);
    assign busy   = ~w_idle;

    // ------------------------------------------------------------------
    // Write path: entry 0 is read-only when the zero register is enabled,
    // and a write qualified away here is also excluded from the bypass.
    // ------------------------------------------------------------------
    assign w_wr_ok  = wr_en & w_idle & ~(c_ZERO_EN & (wr_id == '0));
    assign w_zero_a = c_ZERO_EN & (rd_a_id == '0);
    assign w_zero_b = c_ZERO_EN & (rd_b_id == '0);

    // The memory has no reset of its own; the clear sequencer zeroes it.
    // A write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == c_ST_CLEAR) begin
                r_mem[r_clr_idx] <= '0;
            end else if (w_wr_ok) begin
                r_mem[wr_id] <= wr_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path: write-first bypass, then zero-register override
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_a_val = r_mem[rd_a_id];
        if (w_wr_ok && (wr_id == rd_a_id)) begin
            w_rd_a_val = wr_data;
        end
        if (w_zero_a) begin
            w_rd_a_val = '0;
        end
    end

    always_comb begin
        w_rd_b_val = r_mem[rd_b_id];
        if (w_wr_ok && (wr_id == rd_b_id)) begin
            w_rd_b_val = wr_data;
        end
        if (w_zero_b) begin
            w_rd_b_val = '0;
        end
    end

    // Outputs are zeroed by reset and left untouched during CLEAR, so they
    // read 0 for the whole busy window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_a_data <= '0;
            r_rd_b_data <= '0;
        end else if (w_idle) begin
            if (rd_a_en) begin
                r_rd_a_data <= w_rd_a_val;
            end
            if (rd_b_en) begin
                r_rd_b_data <= w_rd_b_val;
            end
        end
    end

    assign rd_a_data = r_rd_a_data;
    assign rd_b_data = r_rd_b_data;

endmodule
`default_nettype wire

// File: tb/tb_register_file_2r1w.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_file_2r1w
// Description : Directed self-checking bench for register_file_2r1w
//               (DATA_WIDTH=16, ADDR_WIDTH=4, ZERO_REG=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file_2r1w;

    logic        clk;
    logic        rst;
    logic        rd_a_en;
    logic [3:0]  rd_a_id;
    logic [15:0] rd_a_data;
    logic        rd_b_en;
    logic [3:0]  rd_b_id;
    logic [15:0] rd_b_data;
    logic        wr_en;
    logic [3:0]  wr_id;
    logic [15:0] wr_data;
    logic        busy;

    int vectors;
    int miscompares;

    register_file_2r1w #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (4),
        .ZERO_REG   (1)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .rd_a_en   (rd_a_en),
        .rd_a_id   (rd_a_id),
        .rd_a_data (rd_a_data),
        .rd_b_en   (rd_b_en),
        .rd_b_id   (rd_b_id),
        .rd_b_data (rd_b_data),
        .wr_en     (wr_en),
        .wr_id     (wr_id),
        .wr_data   (wr_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs are driven and outputs sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rd_a_en = 1'b0; rd_a_id = 4'd0;
        rd_b_en = 1'b0; rd_b_id = 4'd0;
        wr_en   = 1'b0; wr_id   = 4'd0; wr_data = 16'h0000;
    endtask

    // One reset edge, release, then count edges until busy falls while
    // hammering every request input; outputs must stay 0 throughout.
    task automatic test_reset();
        int n;
        rst = 1'b1;
        tick();
        vectors++;
        if (busy !== 1'b1 || rd_a_data !== 16'h0000 || rd_b_data !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b a=%h b=%h, required busy=1 a=0000 b=0000",
                     busy, rd_a_data, rd_b_data);
        end
        rst = 1'b0;
        rd_a_en = 1'b1; rd_a_id = 4'd5;
        rd_b_en = 1'b1; rd_b_id = 4'd9;
        wr_en = 1'b1; wr_id = 4'd5; wr_data = 16'h1357;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            tick();
            n++;
            if (busy === 1'b1) begin
                vectors++;
                if (rd_a_data !== 16'h0000 || rd_b_data !== 16'h0000) begin
                    miscompares++;
                    $display("FAIL busy_hold_zero: edge %0d a=%h b=%h, required 0000", n, rd_a_data, rd_b_data);
                end
            end
        end
        vectors++;
        if (n != 16) begin
            miscompares++;
            $display("FAIL busy_length: busy edges=%0d, required 16", n);
        end
        idle_inputs();
        for (int i = 0; i < 16; i++) begin
            rd_a_en = 1'b1; rd_a_id = 4'(i);
            rd_b_en = 1'b1; rd_b_id = 4'(15 - i);
            tick();
            vectors++;
            if (rd_a_data !== 16'h0000 || rd_b_data !== 16'h0000) begin
                miscompares++;
                $display("FAIL cleared_read: idx %0d a=%h b=%h, required 0000", i, rd_a_data, rd_b_data);
            end
        end
        idle_inputs();
    endtask

    task automatic test_write_read();
        wr_en = 1'b1; wr_id = 4'd5; wr_data = 16'hBEEF;
        tick();
        idle_inputs();
        rd_a_en = 1'b1; rd_a_id = 4'd5;
        rd_b_en = 1'b1; rd_b_id = 4'd5;
        tick();
        vectors++;
        if (rd_a_data !== 16'hBEEF || rd_b_data !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL write_read: a=%h b=%h, required BEEF BEEF", rd_a_data, rd_b_data);
        end
        idle_inputs();
    endtask

    task automatic test_bypass_hold();
        wr_en = 1'b1; wr_id = 4'd7; wr_data = 16'h1234;
        rd_a_en = 1'b1; rd_a_id = 4'd7;
        tick();
        vectors++;
        if (rd_a_data !== 16'h1234 || rd_b_data !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL bypass_a: a=%h b=%h, required a=1234 b=BEEF", rd_a_data, rd_b_data);
        end
        idle_inputs();
        rd_a_id = 4'd5;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (rd_a_data !== 16'h1234) begin
                miscompares++;
                $display("FAIL hold_a: cycle %0d a=%h, required 1234", i, rd_a_data);
            end
        end
        idle_inputs();
    endtask

    task automatic test_zero_reg();
        wr_en = 1'b1; wr_id = 4'd0; wr_data = 16'hFFFF;
        tick();
        idle_inputs();
        rd_a_en = 1'b1; rd_a_id = 4'd0;
        rd_b_en = 1'b1; rd_b_id = 4'd7;
        tick();
        vectors++;
        if (rd_a_data !== 16'h0000 || rd_b_data !== 16'h1234) begin
            miscompares++;
            $display("FAIL zero_write_ignored: a=%h b=%h, required a=0000 b=1234", rd_a_data, rd_b_data);
        end
        // Load a non-zero value on A first so a missing zero override shows.
        rd_a_id = 4'd5; rd_b_en = 1'b0;
        tick();
        rd_a_id = 4'd0;
        rd_b_en = 1'b1; rd_b_id = 4'd0;
        wr_en = 1'b1; wr_id = 4'd0; wr_data = 16'hFFFF;
        tick();
        vectors++;
        if (rd_a_data !== 16'h0000 || rd_b_data !== 16'h0000) begin
            miscompares++;
            $display("FAIL zero_no_bypass: a=%h b=%h, required 0000 0000", rd_a_data, rd_b_data);
        end
        idle_inputs();
    endtask

    task automatic test_dual_ports();
        wr_en = 1'b1; wr_id = 4'd14; wr_data = 16'h0042;
        tick();
        wr_id = 4'd15; wr_data = 16'h8001;
        rd_a_en = 1'b1; rd_a_id = 4'd15;
        rd_b_en = 1'b1; rd_b_id = 4'd14;
        tick();
        vectors++;
        if (rd_a_data !== 16'h8001 || rd_b_data !== 16'h0042) begin
            miscompares++;
            $display("FAIL dual_read: a=%h b=%h, required a=8001 b=0042", rd_a_data, rd_b_data);
        end
        wr_id = 4'd9; wr_data = 16'h5A5A;
        rd_a_id = 4'd9; rd_b_id = 4'd9;
        tick();
        vectors++;
        if (rd_a_data !== 16'h5A5A || rd_b_data !== 16'h5A5A) begin
            miscompares++;
            $display("FAIL bypass_both: a=%h b=%h, required 5A5A 5A5A", rd_a_data, rd_b_data);
        end
        wr_en = 1'b0;
        rd_a_id = 4'd15; rd_b_id = 4'd9;
        tick();
        vectors++;
        if (rd_a_data !== 16'h8001 || rd_b_data !== 16'h5A5A) begin
            miscompares++;
            $display("FAIL stored_read: a=%h b=%h, required a=8001 b=5A5A", rd_a_data, rd_b_data);
        end
        idle_inputs();
    endtask

    task automatic test_reset_during_clear();
        int n;
        wr_en = 1'b1; wr_id = 4'd3; wr_data = 16'hAAAA;
        tick();
        idle_inputs();
        rd_a_en = 1'b1; rd_a_id = 4'd3;
        tick();
        vectors++;
        if (rd_a_data !== 16'hAAAA) begin
            miscompares++;
            $display("FAIL pre_reset_read: a=%h, required AAAA", rd_a_data);
        end
        idle_inputs();
        rst = 1'b1;
        tick();
        vectors++;
        if (busy !== 1'b1 || rd_a_data !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_from_idle: busy=%b a=%h, required busy=1 a=0000", busy, rd_a_data);
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_mid_clear: busy=%b, required 1", busy);
        end
        rst = 1'b1;
        wr_en = 1'b1; wr_id = 4'd3; wr_data = 16'h5555;
        tick();
        rst = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        vectors++;
        if (n != 16) begin
            miscompares++;
            $display("FAIL restart_busy_length: busy edges=%0d, required 16", n);
        end
        idle_inputs();
        rd_a_en = 1'b1; rd_a_id = 4'd3;
        rd_b_en = 1'b1; rd_b_id = 4'd15;
        tick();
        vectors++;
        if (rd_a_data !== 16'h0000 || rd_b_data !== 16'h0000) begin
            miscompares++;
            $display("FAIL post_restart_read: a=%h b=%h, required 0000 0000", rd_a_data, rd_b_data);
        end
        idle_inputs();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        idle_inputs();
        tick();
        test_reset();
        test_write_read();
        test_bypass_hold();
        test_zero_reg();
        test_dual_ports();
        test_reset_during_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/register_file_2r1w.md
REGISTER_FILE_2R1W -- requirements
Module: register_file_2r1w

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning the bit width of each register.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, meaning the index width; DEPTH = 2**ADDR_WIDTH entries.
REQ-003 SHALL have parameter ZERO_REG, default 1, meaning that entry 0 is hard-wired to zero when set to 1.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port rd_a_en, input, 1 bit: read port A request.
REQ-007 SHALL have port rd_a_id, input, ADDR_WIDTH bits: read port A index.
REQ-008 SHALL have port rd_a_data, output, DATA_WIDTH bits: registered read port A data.
REQ-009 SHALL have port rd_b_en, input, 1 bit: read port B request.
REQ-010 SHALL have port rd_b_id, input, ADDR_WIDTH bits: read port B index.
REQ-011 SHALL have port rd_b_data, output, DATA_WIDTH bits: registered read port B data.
REQ-012 SHALL have port wr_en, input, 1 bit: write request.
REQ-013 SHALL have port wr_id, input, ADDR_WIDTH bits: write index.
REQ-014 SHALL have port wr_data, input, DATA_WIDTH bits: write data.
REQ-015 SHALL have port busy, output, 1 bit: high while the clear sequencer runs; all requests are ignored while it is high.

Function
REQ-016 SHALL implement a two-state FSM with states CLEAR and IDLE.
REQ-017 In CLEAR with rst low, SHALL write zero to mem[clr_idx] and increment clr_idx on each edge.
REQ-018 SHALL leave CLEAR for IDLE on the edge that clears entry DEPTH-1; busy is therefore high for exactly DEPTH cycles after rst deasserts.
REQ-019 In IDLE, SHALL sample rd_a_en/rd_b_en and update rd_x_data one edge later (1-cycle latency).
REQ-020 SHALL hold rd_x_data at its previous value when rd_x_en is low.
REQ-021 In IDLE with wr_en high, SHALL update mem[wr_id] with wr_data at the edge.
REQ-022 SHALL allow reads and a write in the same cycle, and both read ports may address the same index.
REQ-023 When a read index equals wr_id with wr_en high in the same cycle, SHALL return wr_data (write-first bypass).
REQ-024 With ZERO_REG=1, SHALL ignore writes to index 0, return 0 for reads of index 0, and never bypass to index 0.
REQ-025 While busy is high, SHALL ignore rd_x_en and wr_en, and rd_x_data SHALL hold 0.
REQ-026 Read and write data SHALL be passed unmodified at full DATA_WIDTH, with no truncation or extension.

Reset
REQ-027 When rst is sampled high, SHALL enter CLEAR with clr_idx=0, busy=1, rd_a_data=0 and rd_b_data=0, regardless of current state.
REQ-028 Reset asserted during CLEAR SHALL restart clearing from index 0.
REQ-029 Reset asserted during IDLE SHALL discard any same-cycle write.
REQ-030 No entry SHALL be observable through a read port until busy has fallen, so every entry reads 0 after reset.

Verification (DATA_WIDTH=16, ADDR_WIDTH=4, ZERO_REG=1)
REQ-031 Reset 1 cycle, then release -> busy=1 for 16 cycles, then 0; reading every index afterwards -> 0x0000.
REQ-032 Write idx 5=0xBEEF; next cycle read A=5, B=5 -> both ports show 0xBEEF one cycle later.
REQ-033 Write idx 7=0x1234 and read A=7 in the same cycle -> rd_a_data=0x1234 next cycle; then rd_a_en=0 for 3 cycles -> rd_a_data holds 0x1234.
REQ-034 Write idx 0=0xFFFF, then read A=0 -> 0x0000; same-cycle write+read of idx 0 -> 0x0000.
REQ-035 Write idx 3=0xAAAA, assert rst at clear cycle 8, write idx 3 while busy -> busy high 16 cycles after the second release; idx 3 reads 0x0000.
REQ-036 Write 15=0x8001 and read A=15, B=14 simultaneously, with 14 previously holding 0x0042 -> A=0x8001, B=0x0042.
